// File: rtl/mdr_unit.sv
// mdr_unit: memory data register with bus load, timed read/write memory handshake.
// Optional MDR_PARITY_EN adds read parity check (mem_parity) and write parity (mem_wparity).
module mdr_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  MDR_in,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] mar_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ack,
`ifdef MDR_PARITY_EN
  input  logic                  mem_parity,
  output logic                  mem_wparity,
`endif
  output logic [DATA_WIDTH-1:0] mdr_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] mdr_n, wdata_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic req_n, we_n, busy_n, done_n, err_n;
  logic idle, start, rd, tmo, fin, pbad;
`ifdef MDR_PARITY_EN
  logic wpar_n;
  assign pbad = (^mem_data_in) != mem_parity;
`else
  assign pbad = 1'b0;
`endif
  assign idle  = state == IDLE;
  assign start = idle && (read || write);
  assign rd    = state == RD_WAIT;
  assign tmo   = !mem_ack && cnt == LAST;
  assign fin   = !idle && (mem_ack || tmo);
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      mdr_out   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef MDR_PARITY_EN
      mem_wparity <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mdr_out   <= mdr_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
`ifdef MDR_PARITY_EN
      mem_wparity <= wpar_n;
`endif
    end
  always_comb
    state_n = idle ? (read ? RD_WAIT : write ? WR_WAIT : IDLE) : (fin ? IDLE : state);
  // read beats write beats bus load; nothing but a good read ack touches mdr while busy
  always_comb begin
    cnt_n   = (idle || fin) ? 8'd0 : cnt + 8'd1;
    mdr_n   = (idle && !read && !write && MDR_in) ? bus_in :
              (rd && mem_ack && !pbad) ? mem_data_in : mdr_out;
    addr_n  = start ? mar_addr : mem_addr;
    wdata_n = (idle && !read && write) ? mdr_out : mem_wdata;
    req_n   = start ? 1'b1 : fin ? 1'b0 : mem_req;
    we_n    = start ? !read : fin ? 1'b0 : mem_we;
    busy_n  = start ? 1'b1 : fin ? 1'b0 : busy;
    done_n  = fin;
    err_n   = start ? 1'b0 : (fin && (tmo || (rd && mem_ack && pbad))) ? 1'b1 : err;
`ifdef MDR_PARITY_EN
    wpar_n  = (idle && !read && write) ? ^mdr_out : mem_wparity;
`endif
  end
endmodule

// File: tb/tb_mdr_unit.sv
// tb_mdr_unit: directed self-checking bench for mdr_unit (default build).
module tb_mdr_unit;
  logic clock = 1'b0, clear = 1'b1;
  logic [31:0] bus_in = '0, mem_data_in = '0;
  logic MDR_in = 1'b0, read = 1'b0, write = 1'b0, mem_ack = 1'b0;
  logic [8:0] mar_addr = '0;
  logic [31:0] mdr_out, mem_wdata;
  logic [8:0] mem_addr;
  logic mem_req, mem_we, busy, done, err;
  int checks = 0, errors = 0;
`ifdef MDR_PARITY_EN
  logic mem_wparity;
`endif

  mdr_unit dut (
    .clock(clock), .clear(clear), .bus_in(bus_in), .MDR_in(MDR_in),
    .read(read), .write(write), .mar_addr(mar_addr),
    .mem_data_in(mem_data_in), .mem_ack(mem_ack),
`ifdef MDR_PARITY_EN
    .mem_parity(^mem_data_in), .mem_wparity(mem_wparity),
`endif
    .mdr_out(mdr_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mdr"}, mdr_out, 0);
    chk({tag, " addr"}, mem_addr, 0);
    chk({tag, " wdata"}, mem_wdata, 0);
    chk({tag, " ctl"}, {mem_req, mem_we, busy, done, err}, 0);
  endtask

  initial begin
    step();
    chk_zero("reset");
    clear = 1'b0;
    step();
    chk_zero("post_reset");
    // bus load
    bus_in = 32'hDEADBEEF; MDR_in = 1'b1;
    step();
    MDR_in = 1'b0;
    chk("bus_mdr", mdr_out, 32'hDEADBEEF);
    chk("bus_busy_done", {busy, done, mem_req}, 0);
    step();
    chk("bus_done_after", done, 0);
    // read with ack 3 cycles after req
    mar_addr = 9'h05F; read = 1'b1;
    step();
    read = 1'b0;
    chk("rd_start", {mem_req, mem_we, busy}, 3'b101);
    chk("rd_addr", mem_addr, 9'h05F);
    step();
    step();
    chk("rd_wait", {mem_req, busy, done, mdr_out}, {3'b110, 32'hDEADBEEF});
    mem_ack = 1'b1; mem_data_in = 32'h12345678;
    step();
    mem_ack = 1'b0;
    chk("rd_data", mdr_out, 32'h12345678);
    chk("rd_end", {mem_req, mem_we, busy, done, err}, 5'b00010);
    step();
    chk("rd_done_pulse", {done, mdr_out}, {1'b0, 32'h12345678});
    chk("rd_addr_hold", mem_addr, 9'h05F);
    // write with immediate ack
    bus_in = 32'hA5A5A5A5; MDR_in = 1'b1;
    step();
    MDR_in = 1'b0;
    mar_addr = 9'h1FF; write = 1'b1;
    step();
    write = 1'b0;
    chk("wr_start", {mem_req, mem_we, busy}, 3'b111);
    chk("wr_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("wr_addr", mem_addr, 9'h1FF);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_end", {mem_req, mem_we, busy, done}, 4'b0001);
    chk("wr_mdr_kept", mdr_out, 32'hA5A5A5A5);
    step();
    chk("wr_done_pulse", done, 0);
    // timeout
    mar_addr = 9'h010; read = 1'b1;
    step();
    read = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("to_still_waiting", {mem_req, busy, err, done}, 4'b1100);
    step();
    chk("to_abort", {mem_req, mem_we, busy, err, done}, 5'b00011);
    chk("to_mdr_kept", mdr_out, 32'hA5A5A5A5);
    step();
    chk("to_err_sticky", {err, done}, 2'b10);
    bus_in = 32'h11111111; MDR_in = 1'b1;
    step();
    MDR_in = 1'b0;
    chk("to_bus_keeps_err", {err, mdr_out}, {1'b1, 32'h11111111});
    read = 1'b1;
    step();
    read = 1'b0;
    chk("to_read_clears_err", {err, busy}, 2'b01);
    mem_ack = 1'b1; mem_data_in = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    chk("to_reread", {mdr_out, done, err}, {32'hCAFEF00D, 2'b10});
    // contention: read wins, write and bus load dropped
    read = 1'b1; write = 1'b1; MDR_in = 1'b1; bus_in = 32'hFFFFFFFF; mar_addr = 9'h0AA;
    step();
    read = 1'b0;
    chk("ct_read_won", {mem_req, mem_we, busy, mem_addr}, {3'b101, 9'h0AA});
    chk("ct_no_bus", mdr_out, 32'hCAFEF00D);
    step();
    chk("ct_busy_ignore", {mdr_out, mem_we}, {32'hCAFEF00D, 1'b0});
    mem_ack = 1'b1; mem_data_in = 32'h0BADF00D;
    step();
    mem_ack = 1'b0; write = 1'b0; MDR_in = 1'b0;
    chk("ct_mem_data", {mdr_out, done, busy}, {32'h0BADF00D, 2'b10});
    chk("ct_wdata_hold", mem_wdata, 32'hA5A5A5A5);
    // idle ack is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack", {done, busy, mdr_out}, {2'b00, 32'h0BADF00D});
    // async clear in the middle of a read
    read = 1'b1;
    step();
    read = 1'b0;
    chk("rst_mid_busy", busy, 1);
    #2 clear = 1'b1;
    #1 chk_zero("async_clear");
    step();
    clear = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rst_idle", {done, busy, mem_req, mdr_out}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdr_unit.md
Name: mdr_unit

Overview:
- Memory Data Register stage that feeds the MDR input of the datapath bus multiplexer.
- Loads from the 32-bit bus (MDR_in) or from memory via a request/acknowledge read handshake.
- Writes its contents to memory via the same handshake.
- Contains a small FSM and timeout counter so that a slow or absent memory cannot hang the control unit.

Parameters:
- DATA_WIDTH, 32, width of bus, MDR and memory data.
- ADDR_WIDTH, 9, memory word-address width (512 words).
- TIMEOUT, 15, maximum wait cycles for mem_ack before aborting; legal range 1..255.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous active-high reset.
- bus_in  in  DATA_WIDTH  bus multiplexer output.
- MDR_in  in  1  load mdr_out from bus_in.
- read  in  1  start memory read into MDR.
- write  in  1  start memory write from MDR.
- mar_addr  in  ADDR_WIDTH  address from MAR.
- mem_data_in  in  DATA_WIDTH  memory read data.
- mem_ack  in  1  memory completion strobe.
- mdr_out  out  DATA_WIDTH  MDR contents, drives the bus-mux MDR input.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write request, 0 = read request.
- busy  out  1  high while a transaction is outstanding.
- done  out  1  one-cycle pulse at transaction end.
- err  out  1  sticky error flag.

Behaviour:
- Reset: clear is asynchronous and active-high. It forces the following immediately, including mid-transaction:
  - state IDLE
  - mdr_out=0, mem_addr=0, mem_wdata=0
  - mem_req=0, mem_we=0
  - busy=0, done=0, err=0
  - wait counter=0
- All outputs are registered.
- Priority in IDLE is read > write > MDR_in. Lower-priority commands asserted in the same cycle are dropped.
- IDLE, read=1:
  - mem_addr<=mar_addr, mem_we<=0, mem_req<=1, busy<=1, err<=0, counter<=0.
  - Next state RD_WAIT.
- IDLE, write=1 (read=0):
  - mem_addr<=mar_addr, mem_wdata<=mdr_out, mem_we<=1, mem_req<=1, busy<=1, err<=0, counter<=0.
  - Next state WR_WAIT.
- IDLE, MDR_in=1 only: mdr_out<=bus_in at the same edge; no handshake and no done pulse.
- RD_WAIT / WR_WAIT: mem_ack is sampled each edge.
  - ack=1:
    - Read only: mdr_out<=mem_data_in.
    - mem_req<=0, mem_we<=0, busy<=0, done<=1.
    - Next state IDLE.
  - ack=0, counter==TIMEOUT-1:
    - mem_req<=0, mem_we<=0, busy<=0, err<=1, done<=1.
    - mdr_out is unchanged.
    - Next state IDLE.
  - Otherwise: counter increments.
- Minimum read latency: read sampled at edge 0; mem_req high after edge 0; ack sampled at edge 1; mdr_out valid and done high after edge 1.
- done is high for exactly one cycle; the FSM is in IDLE during that cycle and accepts a new command.
- read, write and MDR_in are ignored while busy=1. mdr_out cannot change except via the read completion.
- mem_ack while IDLE is ignored.
- mem_addr and mem_wdata hold their values after a transaction until the next accepted command.
- err stays set until the next accepted read/write or clear. An MDR_in-only load does not clear err.

Optional Feature:
- Macro: MDR_PARITY_EN.
- When defined:
  - Adds input mem_parity (1 bit), the even parity of mem_data_in.
  - On a read ack, if ^mem_data_in != mem_parity: mdr_out is not updated, err<=1, done<=1.
  - Adds output mem_wparity (1 bit) = ^mem_wdata, registered alongside mem_wdata.
- When undefined: neither port exists and there is no parity checking.

Test Plan:
- Reset: assert clear mid-RD_WAIT asynchronously → all outputs 0 before the next clock edge; state IDLE.
- Bus load: bus_in=0xDEADBEEF, MDR_in=1 for 1 cycle → mdr_out=0xDEADBEEF after the edge; busy=0, done never pulses.
- Read: mar_addr=0x05F, read=1; mem_ack asserted 3 cycles after mem_req with mem_data_in=0x12345678 → mem_addr=0x05F, mem_we=0; mdr_out=0x12345678; done pulses once; busy drops the same edge.
- Write: mdr_out=0xA5A5A5A5, mar_addr=0x1FF, write=1, immediate ack → mem_wdata=0xA5A5A5A5, mem_we=1 for 1 cycle, done pulse, mdr_out unchanged.
- Timeout: read with no ack, TIMEOUT=15 → mem_req drops after 15 wait cycles, err=1, done pulse, mdr_out retains its prior value; next read clears err.
- Contention: read=write=MDR_in=1 in IDLE → read transaction only. During busy, assert write and MDR_in with bus_in=0xFFFFFFFF → both ignored; mdr_out = memory data only.
